// File: rtl/mm_controller.sv
// mm_controller: sequencer for a TILE x TILE systolic matrix multiply.
// Walks the (j, i, h) tile loop and drives address-phase selects and strobes.
// The data-phase selects are the same values delayed by one cycle, which
// matches the one-cycle memory read latency.
// Optional feature: define MM_CTRL_PERF_EN to build the busy-cycle counter.
module mm_controller #(
  parameter int TILE  = 4,
  parameter int DIM_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] M,
  input  logic [DIM_W-1:0] N,
  input  logic [DIM_W-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             i_cnt,
  output logic             j_cnt,
  output logic             h_cnt,
  output logic             i_clr,
  output logic             h_clr,
  output logic             base_cal,
  output logic [1:0]       addr_sel,
  output logic [3:0]       bi2_sel,
  output logic [1:0]       dout_sel,
  output logic [1:0]       w_sel,
  output logic [1:0]       i_sel,
  output logic [1:0]       fpo_sel,
  output logic             mem_we,
  output logic [31:0]      perf_cycles
);

  localparam int LG = $clog2(TILE);
  localparam int HW = DIM_W + 1;  // h runs up to M+TILE-1

  typedef enum logic [3:0] {
    IDLE, BASE, LOAD_W, STREAM_IN, WB_RD, WB_WR, NEXT_H, NEXT_TILE, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [HW-1:0]    h_q, h_d;
  logic [DIM_W-1:0] i_q, i_d, j_q, j_d;
  logic [DIM_W-1:0] m_q, m_d, ni_q, ni_d, nk_q, nk_d;
  logic             err_q, err_d;
  logic [1:0]       dout_sel_q, dout_sel_d;
  logic [1:0]       w_sel_q, w_sel_d;
  logic [1:0]       i_sel_q, i_sel_d;
  logic [1:0]       fpo_sel_q, fpo_sel_d;

  logic             job_ok;
  logic [HW-1:0]    h_next, m_ext, h_end;
  state_t           after_stream, after_next_h;

  // A job is legal when all dimensions are nonzero and N, K are whole tiles.
  assign job_ok = (M != '0) && (N != '0) && (K != '0) &&
                  (N[LG-1:0] == '0) && (K[LG-1:0] == '0);

  assign m_ext  = {1'b0, m_q};
  assign h_next = h_q + HW'(1);
  assign h_end  = m_ext + HW'(TILE);

  // Where to go once the current h has streamed, and what the next h needs.
  always_comb begin
    after_stream = (h_q >= HW'(TILE)) ? WB_RD : NEXT_H;
    if (h_next == h_end)           after_next_h = NEXT_TILE;
    else if (h_next < m_ext)       after_next_h = STREAM_IN;
    else if (h_next >= HW'(TILE))  after_next_h = WB_RD;
    else                           after_next_h = NEXT_H;
  end

  // Next-state, loop counters and address-phase outputs.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    h_d        = h_q;
    i_d        = i_q;
    j_d        = j_q;
    m_d        = m_q;
    ni_d       = ni_q;
    nk_d       = nk_q;
    err_d      = err_q;
    dout_sel_d = 2'b11;
    w_sel_d    = 2'b00;
    i_sel_d    = 2'b00;
    fpo_sel_d  = 2'b00;
    done       = 1'b0;
    err        = 1'b0;
    i_cnt      = 1'b0;
    j_cnt      = 1'b0;
    h_cnt      = 1'b0;
    i_clr      = 1'b0;
    h_clr      = 1'b0;
    base_cal   = 1'b0;
    addr_sel   = 2'b11;
    bi2_sel    = 4'd0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d  = M;
          ni_d = N >> LG;
          nk_d = K >> LG;
          i_d  = '0;
          j_d  = '0;
          if (job_ok) begin
            state_d = BASE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BASE: begin
        base_cal = 1'b1;
        h_clr    = 1'b1;
        i_clr    = (i_q == '0);
        h_d      = '0;
        s_d      = '0;
        state_d  = LOAD_W;
      end
      LOAD_W: begin
        addr_sel   = 2'b00;
        bi2_sel    = s_q;
        dout_sel_d = 2'b00;
        w_sel_d    = s_q[1:0];
        s_d        = s_q + 4'd1;
        if (s_q == 4'(TILE*TILE-1)) begin
          s_d     = '0;
          state_d = STREAM_IN;  // h=0 < M always holds for a legal job
        end
      end
      STREAM_IN: begin
        addr_sel   = 2'b01;
        bi2_sel    = s_q;
        dout_sel_d = 2'b01;
        i_sel_d    = s_q[1:0];
        s_d        = s_q + 4'd1;
        if (s_q == 4'(TILE-1)) begin
          s_d     = '0;
          state_d = after_stream;
        end
      end
      WB_RD, WB_WR: begin
        addr_sel   = 2'b10;
        bi2_sel    = s_q;
        // First i tile has no prior partial sum: steer a forced zero.
        dout_sel_d = (i_q == '0) ? 2'b11 : 2'b10;
        fpo_sel_d  = s_q[1:0];
        if (state_q == WB_RD) begin
          state_d = WB_WR;
        end else begin
          mem_we  = 1'b1;
          s_d     = s_q + 4'd1;
          state_d = WB_RD;
          if (s_q == 4'(TILE-1)) begin
            s_d     = '0;
            state_d = NEXT_H;
          end
        end
      end
      NEXT_H: begin
        h_cnt   = 1'b1;
        h_d     = h_next;
        state_d = after_next_h;
      end
      NEXT_TILE: begin
        if (i_q != ni_q - DIM_W'(1)) begin
          i_cnt   = 1'b1;
          i_d     = i_q + DIM_W'(1);
          state_d = BASE;
        end else begin
          j_cnt = 1'b1;
          i_clr = 1'b1;
          i_d   = '0;
          if (j_q == nk_q - DIM_W'(1)) begin
            state_d = DONE;
          end else begin
            j_d     = j_q + DIM_W'(1);
            state_d = BASE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, loop counters and the one-cycle data-phase delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      h_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      m_q        <= '0;
      ni_q       <= '0;
      nk_q       <= '0;
      err_q      <= 1'b0;
      dout_sel_q <= 2'b11;
      w_sel_q    <= 2'b00;
      i_sel_q    <= 2'b00;
      fpo_sel_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      h_q        <= h_d;
      i_q        <= i_d;
      j_q        <= j_d;
      m_q        <= m_d;
      ni_q       <= ni_d;
      nk_q       <= nk_d;
      err_q      <= err_d;
      dout_sel_q <= dout_sel_d;
      w_sel_q    <= w_sel_d;
      i_sel_q    <= i_sel_d;
      fpo_sel_q  <= fpo_sel_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign dout_sel = dout_sel_q;
  assign w_sel    = w_sel_q;
  assign i_sel    = i_sel_q;
  assign fpo_sel  = fpo_sel_q;

`ifdef MM_CTRL_PERF_EN
  logic        accept;
  logic [31:0] perf_q, perf_d;

  assign accept = (state_q == IDLE) && start && job_ok;

  // Count the working cycles of an accepted job; frozen in DONE and IDLE.
  always_comb begin
    perf_d = perf_q;
    if (accept)
      perf_d = '0;
    else if (state_q != IDLE && state_q != DONE)
      perf_d = perf_q + 32'd1;
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
